// File: rtl/tmr_fault_manager_if.sv
// tmr_fault_manager_if: replica buses in, voted bus and supervisor status out.
// TMR_ERR_INJECT_EN adds the err_ctrl fault-injection lines.
interface tmr_fault_manager_if #(parameter int W = 8);
    logic         valid;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [W-1:0] data_c;
    logic [W-1:0] data_out;
    logic [1:0]   mode;
    logic [2:0]   fault_vec;
    logic [2:0]   rep_rst_n;
    logic         tmr_error;
`ifdef TMR_ERR_INJECT_EN
    logic [2:0]   err_ctrl;
    modport slave (input valid, data_a, data_b, data_c, err_ctrl,
                   output data_out, mode, fault_vec, rep_rst_n, tmr_error);
    modport master (output valid, data_a, data_b, data_c, err_ctrl,
                    input data_out, mode, fault_vec, rep_rst_n, tmr_error);
`else
    modport slave (input valid, data_a, data_b, data_c,
                   output data_out, mode, fault_vec, rep_rst_n, tmr_error);
    modport master (output valid, data_a, data_b, data_c,
                    input data_out, mode, fault_vec, rep_rst_n, tmr_error);
`endif
endinterface

// File: rtl/tmr_fault_manager.sv
// tmr_fault_manager: votes three replica buses, fences/resyncs a faulty replica, sticks in FAIL.
// Optional TMR_ERR_INJECT_EN: per-replica bus inversion before voting.
module tmr_fault_manager #(
    parameter int W            = 8,
    parameter int FAULT_THRESH = 4,
    parameter int RESYNC_CYC   = 16,
    parameter int PROBATION    = 32,
    parameter int MAX_RETRY    = 2
) (
    input logic                 clk,
    input logic                 rst,
    tmr_fault_manager_if.slave  bus
);
    localparam int FW = $clog2(FAULT_THRESH + 1);
    localparam int RW = $clog2(RESYNC_CYC + 1);
    localparam int PW = $clog2(PROBATION + 1);
    localparam int TW = $clog2(MAX_RETRY + 2);
    localparam logic [FW-1:0] FT      = FW'(FAULT_THRESH);
    localparam logic [RW-1:0] RS_LAST = RW'(RESYNC_CYC - 1);
    localparam logic [PW-1:0] PR_LAST = PW'(PROBATION - 1);
    localparam logic [TW-1:0] RT_MAX  = TW'(MAX_RETRY);

    typedef enum logic [2:0] {ST_TMR, ST_RESET, ST_PROBE, ST_PERM, ST_FAIL} state_t;

    state_t        r_state;
    logic [1:0]    r_mode;
    logic [2:0]    r_fvec;
    logic [2:0]    r_rrn;
    logic          r_err;
    logic [FW-1:0] r_mis [3];
    logic [FW-1:0] r_pair;
    logic [RW-1:0] r_rs;
    logic [PW-1:0] r_prob;
    logic [TW-1:0] r_retry;

    logic [W-1:0]  w_d [3];
    logic [W-1:0]  w_maj;
    logic [FW-1:0] w_mis_nxt [3];
    logic [FW-1:0] w_pair_nxt;
    logic [2:0]    w_hit;
    logic [1:0]    w_f, w_p0, w_p1;
    logic          w_dup, w_pdis, w_fmm, w_multi;

`ifdef TMR_ERR_INJECT_EN
    assign w_d[0] = bus.data_a ^ {W{bus.err_ctrl[0]}};
    assign w_d[1] = bus.data_b ^ {W{bus.err_ctrl[1]}};
    assign w_d[2] = bus.data_c ^ {W{bus.err_ctrl[2]}};
`else
    assign w_d[0] = bus.data_a;
    assign w_d[1] = bus.data_b;
    assign w_d[2] = bus.data_c;
`endif

    assign w_maj = (w_d[0] & w_d[1]) | (w_d[1] & w_d[2]) | (w_d[0] & w_d[2]);
    // healthy pair is the two replicas not marked in fault_vec, lower index first
    assign w_f   = r_fvec[1] ? 2'd1 : (r_fvec[2] ? 2'd2 : 2'd0);
    assign w_p0  = r_fvec[0] ? 2'd1 : 2'd0;
    assign w_p1  = r_fvec[2] ? 2'd1 : 2'd2;
    assign w_dup = (r_state == ST_RESET) || (r_state == ST_PROBE) || (r_state == ST_PERM);
    assign w_pdis = bus.valid && (w_d[w_p0] != w_d[w_p1]);
    assign w_fmm  = w_d[w_f] != w_d[w_p0];
    assign w_pair_nxt = !bus.valid ? r_pair : (w_pdis ? (r_pair == FT ? r_pair : r_pair + 1'b1) : '0);
    assign w_multi = (w_hit[0] & w_hit[1]) | (w_hit[1] & w_hit[2]) | (w_hit[0] & w_hit[2]);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_mis_nxt[i] = !bus.valid ? r_mis[i] :
                           (w_d[i] != w_maj) ? (r_mis[i] == FT ? r_mis[i] : r_mis[i] + 1'b1) : '0;
            w_hit[i]     = w_mis_nxt[i] == FT;
        end
    end

    assign bus.data_out  = w_dup ? w_d[w_p0] : w_maj;
    assign bus.mode      = r_mode;
    assign bus.fault_vec = r_fvec;
    assign bus.rep_rst_n = r_rrn;
    assign bus.tmr_error = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_TMR;
            r_mode  <= 2'b00;
            r_fvec  <= 3'b000;
            r_rrn   <= 3'b111;
            r_err   <= 1'b0;
            r_mis   <= '{default: '0};
            r_pair  <= '0;
            r_rs    <= '0;
            r_prob  <= '0;
            r_retry <= '0;
        end else begin
            case (r_state)
                ST_TMR: begin
                    r_mis <= w_mis_nxt;
                    if (w_multi) begin
                        r_state <= ST_FAIL;
                        r_mode  <= 2'b11;
                        r_err   <= 1'b1;
                    end else if (|w_hit) begin
                        r_state <= ST_RESET;
                        r_mode  <= 2'b01;
                        r_fvec  <= w_hit;
                        r_rrn   <= ~w_hit;
                        r_mis   <= '{default: '0};
                        r_pair  <= '0;
                        r_rs    <= '0;
                        r_prob  <= '0;
                        r_retry <= '0;
                    end
                end
                ST_RESET, ST_PROBE, ST_PERM: begin
                    r_pair <= w_pair_nxt;
                    if (w_pair_nxt == FT) begin
                        r_state <= ST_FAIL;
                        r_mode  <= 2'b11;
                        r_err   <= 1'b1;
                        r_rrn   <= 3'b111;
                    end else if (r_state == ST_RESET) begin
                        r_rs <= r_rs + 1'b1;
                        if (r_rs == RS_LAST) begin
                            r_state <= ST_PROBE;
                            r_rrn   <= 3'b111;
                        end
                    end else if (r_state == ST_PROBE && bus.valid && !w_pdis) begin
                        if (w_fmm) begin
                            r_rrn   <= ~r_fvec;
                            r_state <= (r_retry == RT_MAX) ? ST_PERM : ST_RESET;
                            r_retry <= r_retry + 1'b1;
                            r_rs    <= '0;
                            r_prob  <= '0;
                        end else if (r_prob == PR_LAST) begin
                            r_state <= ST_TMR;
                            r_mode  <= 2'b00;
                            r_fvec  <= 3'b000;
                            r_pair  <= '0;
                            r_prob  <= '0;
                            r_retry <= '0;
                        end else begin
                            r_prob <= r_prob + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/tmr_fault_manager.md
# tmr_fault_manager

Supervisor for the triple-redundant NFC datapath. It watches the three replica output buses and votes them onto a single output. It fences a replica that persistently disagrees, holds that replica in reset, re-admits it after a probation window, and escalates to a sticky FAIL state when redundancy is lost. It sits between the three NFC replicas and the flash pins, in place of the bare bitwise voters.

## Interface
- `W`, 8, width of each replica bus.
- `FAULT_THRESH`, 4, consecutive mismatching valid cycles that trigger a fence or a fail (≥1).
- `RESYNC_CYC`, 16, cycles a fenced replica's reset is held low (≥1).
- `PROBATION`, 32, consecutive matching valid cycles required for re-admission (≥1).
- `MAX_RETRY`, 2, failed probation attempts allowed before a replica is fenced permanently.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `valid` input 1: compare enable; mismatch and probation counters evaluate only when high.
- `data_a`, `data_b`, `data_c` input W: replica A/B/C outputs.
- `data_out` output W: voted or selected bus, combinational.
- `mode` output 2: 00 TMR, 01 DUPLEX, 11 FAIL; registered.
- `fault_vec` output 3: one-hot fenced replica, bit0 = A; registered.
- `rep_rst_n` output 3: per-replica reset request, active-low; registered.
- `tmr_error` output 1: sticky fail flag; registered.

## Operation
- Majority is defined bitwise as `maj = (a&b)|(b&c)|(a&c)`.
- Replica X mismatches on a cycle when `valid` is high and `data_X != maj`.
- Each replica has a consecutive-mismatch counter.
  - A valid matching cycle clears it.
  - A cycle with `valid` low holds it.
  - The counter saturates at FAULT_THRESH.
- **TMR state**
  - `data_out = maj`.
  - When exactly one counter reaches FAULT_THRESH: go to DUPLEX, set that replica's `fault_vec` bit, drive its `rep_rst_n` low, and clear the retry count and all counters.
  - When two or more counters reach the threshold on the same edge: go to FAIL.
- **DUPLEX state**
  - Sub-states are RS_RESET and RS_PROBE.
  - `data_out` is the data of the lower-index healthy replica.
  - Healthy-pair disagreement is tracked on its own counter (valid cycles with the pair unequal). Reaching FAULT_THRESH sends the block to FAIL from either sub-state.
  - **RS_RESET:** `rep_rst_n` of the fenced replica is low for RESYNC_CYC cycles, then the sub-state goes to RS_PROBE with `rep_rst_n` released.
  - **RS_PROBE:** the probation counter increments on valid cycles where the pair agrees and the fenced replica equals the pair.
    - `valid` low holds the counter.
    - Pair disagreement holds the counter.
    - A fenced-replica mismatch while the pair agrees increments the retry count and returns to RS_RESET (count cleared).
    - Reaching PROBATION returns to TMR with `fault_vec` cleared and all counters cleared.
  - When the retry count would exceed MAX_RETRY: stay in DUPLEX permanently with `rep_rst_n` held low. Pair-disagreement escalation to FAIL remains active.
- **FAIL state**
  - `data_out = maj`, `mode = 11`, `tmr_error = 1`, `rep_rst_n = 111`.
  - `fault_vec` holds its last value.
  - The only exit is `rst`.

## Timing
- `data_out`: zero latency, combinational from the inputs and the registered state.
- A fence or fail is decided on the edge that ends the FAULT_THRESH-th qualifying cycle. `mode`, `fault_vec`, `rep_rst_n` and `tmr_error` change right after that edge.
  - During the deciding cycle, `data_out` still uses the old state's selection.
- `rep_rst_n` is low for exactly RESYNC_CYC cycles per attempt.
- Re-admission: `mode` returns to 00 on the edge ending the PROBATION-th matching cycle.
- Reset: `rst` low clears everything immediately, including mid-resync or in FAIL.
  - `mode = 00`, `fault_vec = 000`, `rep_rst_n = 111`, `tmr_error = 0`, all counters 0.
- Precedence on the same edge: FAIL beats fence, and fence beats probation progress.

## Configuration
- `TMR_ERR_INJECT_EN` defined:
  - Adds input `err_ctrl[2:0]`.
  - While `err_ctrl[i]` is set, replica i's bus is inverted before any vote, compare or select.
  - `data_out` reflects the inverted value if that replica is selected.
- `TMR_ERR_INJECT_EN` undefined: the port is absent and no inversion logic is built.

## Test plan
All scenarios use the default parameter values.
1. A = B = C = 8'h5A, `valid` high, 100 cycles → `data_out` 5A, `mode` 00, `fault_vec` 000, `rep_rst_n` 111.
2. B = FF, A = C = 00 for 4 valid cycles → after the 4th edge: `fault_vec` 010, `mode` 01, `rep_rst_n[1]` low for 16 cycles; `data_out` 00 throughout.
3. B mismatches 3 cycles, matches 1, repeated 20 times, with `valid` toggling → B is never fenced, `mode` stays 00.
4. After scenario 2, B matches for 32 valid cycles (with 5 interleaved `valid`-low cycles) → `mode` 00 and `fault_vec` 000 after the 32nd matching edge.
5. During probation, B mismatches once, three times in a row → two re-resets of 16 cycles each, then `rep_rst_n[1]` held low and `mode` 01 permanently.
6. B fenced, A = 11, C = 22 for 4 valid cycles → `mode` 11, `tmr_error` 1 sticky; then `rst` low mid-cycle → all outputs return to reset values asynchronously.
